// File: rtl/demux_scheduler.sv
// rtl/demux_scheduler.sv - 1-to-8 demux sequencer, round-robin or explicit destination; optional HOLD timeout via DEMUX_TIMEOUT_EN
module demux_scheduler #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_mode,
  input  logic [2:0]       i_dest,
  input  logic [7:0]       i_out_ready,
  output logic [2:0]       o_control,
  output logic [7:0]       o_out_valid,
  output logic [WIDTH-1:0] o_outputs,
  output logic             o_busy,
  output logic             o_drop
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_rr_ptr;
  logic [2:0]       r_control;
  logic [WIDTH-1:0] r_hold;
  logic             w_capture;
  logic             w_xfer;
  logic             w_timeout;
  logic             w_target_ready;

  // Reject timeout values the 8-bit HOLD counter cannot represent
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("demux_scheduler: TIMEOUT out of range 2..255");
  end

`ifdef DEMUX_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_drop;
  logic       w_cnt_last;

  // Last stalled HOLD cycle before the word is abandoned
  assign w_cnt_last = (r_cnt == 8'(TIMEOUT - 1));

  // HOLD stall counter; cleared on capture, counts cycles the target is not ready
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_timeout;
      if (w_capture) begin
        r_cnt <= '0;
      end else if (r_state == HOLD && !w_target_ready) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_drop = r_drop;
`else
  assign o_drop = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; the held target is the only channel whose ready matters
  always_comb begin
    w_next_state   = r_state;
    w_capture      = 1'b0;
    w_xfer         = 1'b0;
    w_timeout      = 1'b0;
    w_target_ready = i_out_ready[r_control];
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_capture    = 1'b1;
          w_next_state = HOLD;
        end
      end
      HOLD: begin
        if (w_target_ready) begin
          w_xfer       = 1'b1;
          w_next_state = IDLE;
        end
`ifdef DEMUX_TIMEOUT_EN
        else if (w_cnt_last) begin
          w_timeout    = 1'b1;
          w_next_state = IDLE;
        end
`endif
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Word/target capture and round-robin pointer; mode and dest only matter at capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold    <= '0;
      r_control <= '0;
      r_rr_ptr  <= '0;
    end else begin
      if (w_capture) begin
        r_hold    <= i_data;
        r_control <= i_mode ? i_dest : r_rr_ptr;
      end
      if (w_xfer || w_timeout) begin
        r_rr_ptr <= r_control + 3'd1;
      end
    end
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    o_in_ready  = (r_state == IDLE);
    o_busy      = (r_state == HOLD);
    o_out_valid = 8'h00;
    if (r_state == HOLD) begin
      o_out_valid = 8'h01 << r_control;
    end
  end

  assign o_control = r_control;
  assign o_outputs = r_hold;

endmodule

// File: tb/tb_demux_scheduler.sv
// tb/tb_demux_scheduler.sv - table-driven bench for demux_scheduler
module tb_demux_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [2:0] dest;
  logic [7:0] out_ready;
  logic [2:0] control;
  logic [7:0] out_valid;
  logic [7:0] outputs;
  logic       busy;
  logic       drop;

  int errs   = 0;
  int checks = 0;

  demux_scheduler #(.WIDTH(8), .TIMEOUT(8)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_data      (data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_mode      (mode),
    .i_dest      (dest),
    .i_out_ready (out_ready),
    .o_control   (control),
    .o_out_valid (out_valid),
    .o_outputs   (outputs),
    .o_busy      (busy),
    .o_drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       md;
    logic [2:0] ds;
    logic [7:0] ordy;
    logic       e_irdy;
    logic [2:0] e_ctrl;
    logic [7:0] e_ov;
    logic [7:0] e_out;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic vld, input logic [7:0] d, input logic md, input logic [2:0] ds,
                     input logic [7:0] ordy, input logic e_irdy, input logic [2:0] e_ctrl,
                     input logic [7:0] e_ov, input logic [7:0] e_out, input logic e_busy);
    vec_t v;
    v.vld = vld; v.d = d; v.md = md; v.ds = ds; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ctrl = e_ctrl; v.e_ov = e_ov; v.e_out = e_out; v.e_busy = e_busy;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; in_valid = 1'b0; mode = 1'b0; dest = 3'd0; out_ready = 8'h00;

    // Round-robin sweep, 9 words, one per 2 cycles; in_valid kept high through HOLD
    for (int i = 0; i < 9; i++) begin
      add(1'b1, 8'h10 + 8'(i), 1'b0, 3'd0, 8'hFF, 1'b0, 3'(i % 8), 8'h01 << (i % 8), 8'h10 + 8'(i), 1'b1);
      add(1'b1, 8'h10 + 8'(i), 1'b0, 3'd0, 8'hFF, 1'b1, 3'(i % 8), 8'h00,           8'h10 + 8'(i), 1'b0);
    end
    // Fixed destination 5, then round-robin follows to 6; non-target ready ignored
    add(1'b1, 8'h55, 1'b1, 3'd5, 8'h20, 1'b0, 3'd5, 8'h20, 8'h55, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'd2, 8'h20, 1'b1, 3'd5, 8'h00, 8'h55, 1'b0);
    add(1'b1, 8'h66, 1'b0, 3'd0, 8'h00, 1'b0, 3'd6, 8'h40, 8'h66, 1'b1);
    add(1'b1, 8'hEE, 1'b1, 3'd1, 8'hBF, 1'b0, 3'd6, 8'h40, 8'h66, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'd0, 8'h40, 1'b1, 3'd6, 8'h00, 8'h66, 1'b0);
    // Back-pressure on channel 2: valid visible 8 cycles, transfer on the 8th
    add(1'b1, 8'h77, 1'b1, 3'd2, 8'hFB, 1'b0, 3'd2, 8'h04, 8'h77, 1'b1);
    for (int i = 0; i < 7; i++)
      add(1'b1, 8'h00, 1'b0, 3'd0, 8'hFB, 1'b0, 3'd2, 8'h04, 8'h77, 1'b1);
    add(1'b0, 8'h00, 1'b0, 3'd0, 8'hFF, 1'b1, 3'd2, 8'h00, 8'h77, 1'b0);

    // Reset values, applied asynchronously before any clock edge
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_control",   control,   0);
    chk("rst_outputs",   outputs,   0);
    chk("rst_busy",      busy,      0);
    chk("rst_drop",      drop,      0);
    in_valid = 1'b1; data = 8'hAB;
    step();
    chk("rst_no_capture", busy, 0);
    chk("rst_in_ready2",  in_ready, 1);
    in_valid = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) begin
      in_valid = tbl[i].vld; data = tbl[i].d; mode = tbl[i].md; dest = tbl[i].ds; out_ready = tbl[i].ordy;
      step();
      chk($sformatf("v%0d_in_ready", i),  in_ready,  tbl[i].e_irdy);
      chk($sformatf("v%0d_control", i),   control,   tbl[i].e_ctrl);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_outputs", i),   outputs,   tbl[i].e_out);
      chk($sformatf("v%0d_busy", i),      busy,      tbl[i].e_busy);
      chk($sformatf("v%0d_drop", i),      drop,      0);
    end

    // Reset mid-HOLD with rr_ptr = 3
    in_valid = 1'b1; mode = 1'b0; data = 8'h88; out_ready = 8'h00;
    step();
    chk("mr_ctrl", control, 3);
    chk("mr_ov",   out_valid, 8'h08);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mr_async_ov",   out_valid, 0);
    chk("mr_async_busy", busy, 0);
    chk("mr_async_ctrl", control, 0);
    chk("mr_async_out",  outputs, 0);
    chk("mr_async_drop", drop, 0);
    in_valid = 1'b1; data = 8'h99;
    step();
    chk("mr_held_idle", busy, 0);
    rst = 1'b0;
    step();
    chk("mr_after_ctrl", control, 0);
    chk("mr_after_ov",   out_valid, 8'h01);
    chk("mr_after_out",  outputs, 8'h99);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
    chk("mr_after_idle", in_ready, 1);

    // Stall on channel 7; rr_ptr is 1 here
    in_valid = 1'b1; mode = 1'b1; dest = 3'd7; data = 8'hC7; out_ready = 8'h00;
    step();
    in_valid = 1'b0; mode = 1'b0;
    chk("to_ov", out_valid, 8'h80);
`ifdef DEMUX_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("to_wait%0d_busy", i), busy, 1);
      chk($sformatf("to_wait%0d_drop", i), drop, 0);
    end
    step();
    chk("to_drop",      drop, 1);
    chk("to_drop_busy", busy, 0);
    chk("to_drop_ov",   out_valid, 0);
    in_valid = 1'b1; data = 8'h01;
    step();
    chk("to_drop_pulse", drop, 0);
    chk("to_next_ctrl",  control, 0);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
    // Variant: target ready arrives in the final timeout cycle
    in_valid = 1'b1; mode = 1'b1; dest = 3'd7; out_ready = 8'h00;
    step();
    in_valid = 1'b0; mode = 1'b0;
    for (int i = 0; i < 7; i++) step();
    out_ready = 8'h80;
    step();
    chk("tv_busy", busy, 0);
    chk("tv_drop", drop, 0);
    out_ready = 8'h00;
    step();
    chk("tv_drop_next", drop, 0);
    in_valid = 1'b1;
    step();
    chk("tv_next_ctrl", control, 0);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
`else
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("stall%0d_busy", i), busy, 1);
      chk($sformatf("stall%0d_drop", i), drop, 0);
    end
    out_ready = 8'h80;
    step();
    chk("stall_release", busy, 0);
    in_valid = 1'b1; out_ready = 8'h00;
    step();
    chk("stall_next_ctrl", control, 0);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
`endif
    chk("end_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/demux_scheduler.md
# demux_scheduler

Sequencing controller for the 1-to-8 demultiplexer datapath: accepts words from a single upstream source over a valid/ready handshake, holds each one, and delivers it to exactly one of eight downstream channels. Destination is either round-robin or explicitly requested. The block drives the 3-bit channel select and the one-hot per-channel valid that steer the demux, and waits for the selected channel's ready before taking the next word.

## Interface
- `WIDTH`, default 1: data word width in bits.
- `TIMEOUT`, default 16: HOLD cycles without downstream ready before a drop. Range 2..255; used only with `DEMUX_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `data` input WIDTH: upstream word.
- `in_valid` input 1: upstream word present.
- `in_ready` output 1: block can capture a word this cycle.
- `mode` input 1: 0 = round-robin destination; 1 = destination taken from `dest`.
- `dest` input 3: requested channel, used when `mode` = 1.
- `out_ready` input 8: per-channel ready from the downstream consumers.
- `control` output 3: currently selected channel (demux select).
- `out_valid` output 8: one-hot valid for the selected channel; all zero when idle.
- `outputs` output WIDTH: held word, shared by all channels; qualified by `out_valid`.
- `busy` output 1: high in the HOLD state.
- `drop` output 1: one-cycle pulse when a word is discarded on timeout.

## Operation
- Two-state FSM: IDLE, HOLD. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0, `busy` = 0.
  - On `in_valid` & `in_ready`: capture `data` into the hold register and compute the target channel, then go to HOLD.
  - Target is `dest` when `mode` = 1, or the round-robin pointer `rr_ptr` when `mode` = 0.
- HOLD:
  - `in_ready` = 0, `busy` = 1, `control` = target, `out_valid` = 1 << target, `outputs` = held word.
  - Transfer occurs at the edge where `out_ready[target]` = 1. Then go to IDLE and set `rr_ptr` = target + 1 (mod 8, 7 wraps to 0).
- `rr_ptr` advances only on a transfer or a drop, never on capture. It advances in both modes, so a later round-robin word follows the last served channel.
- `mode` and `dest` are sampled only at capture. Changes during HOLD have no effect on the held word.
- `out_ready` bits of non-target channels are ignored.
- `control` holds its last target while IDLE. `out_valid` = 0 makes that value inert.
- Reset values: state IDLE, `rr_ptr` = 0, `control` = 0, `out_valid` = 0, `outputs` = 0, `busy` = 0, `drop` = 0.
  - `in_ready` reads 1 during reset, but no capture occurs while `rst` is high.
- Reset during HOLD: the held word is discarded with no `drop` pulse, and all state returns to its reset values immediately.

## Timing
- Capture at edge N: `out_valid` and `control` valid from cycle N+1 (one-cycle latency).
- Minimum transfer at edge N+1 (`out_ready` already high): `in_ready` = 1 again in cycle N+2. Peak throughput is one word per 2 cycles.
- No combinational path from `in_valid` to any output.
- `in_ready` and `out_valid` are decoded from registered state.
- `outputs` and `control` are registered.

## Configuration
- `DEMUX_TIMEOUT_EN` defined:
  - A counter clears on entry to HOLD and increments every HOLD cycle in which `out_ready[target]` = 0.
  - When the count reaches `TIMEOUT`, then at that edge: go to IDLE, pulse `drop` for one cycle, and advance `rr_ptr` = target + 1.
  - If `out_ready[target]` = 1 in the timeout cycle, the transfer wins and no drop occurs.
- Undefined:
  - HOLD lasts indefinitely until the target is ready.
  - `drop` is tied to 0.
  - No counter logic; `TIMEOUT` is ignored.

## Test plan
- Round-robin sweep: `mode` = 0, `out_ready` = 8'hFF, 9 words 0,1,0,1,… streamed → `control` 0,1,…,7,0; `out_valid` 01,02,…,80,01; one word per 2 cycles.
- Fixed destination: `mode` = 1, `dest` = 5, word 1, `out_ready` = 8'h20 → `out_valid` = 8'h20 one cycle; next round-robin word goes to channel 6.
- Back-pressure: target 2, `out_ready` = 8'hFB for 7 cycles then 8'hFF → `out_valid` = 8'h04 held 8 cycles; `in_ready` = 0 throughout; transfer on 8th.
- Reset mid-HOLD: assert `rst` asynchronously during HOLD with `rr_ptr` = 3 → `out_valid` = 0 immediately; after release, first word goes to channel 0.
- Timeout (`DEMUX_TIMEOUT_EN`, `TIMEOUT` = 4): target 7, `out_ready` = 0 → `drop` pulses after 4 HOLD cycles; next word goes to channel 0. Variant: `out_ready[7]` rises in cycle 4 → transfer, no `drop`.
